pfiform_pop_reader: RTL

//  Consumer for the PFIFORM pop-side interface. Captures 96-bit PopData words over the

---
 rtl/pfiform_pop_reader.sv | 134 +++++++++++++
 1 files changed

// File: rtl/pfiform_pop_reader.sv
// PFIFORM pop-side reader: buffers PopData words and replays their valid bytes as a byte stream.
// Optional statistics counters are enabled by defining PFIFORM_RD_STATS_EN.
module pfiform_pop_reader #(
    parameter int BYTE_W         = 8,
    parameter int BYTES_PER_WORD = 12,
    parameter int DEPTH          = 2
) (
    input  logic                             i_core_clk,
    input  logic                             i_rx_rstn,
    input  logic                             PopEnable,
    output logic                             PopPermit,
    input  logic [3:0]                       PopAmout,
    input  logic [BYTE_W*BYTES_PER_WORD-1:0] PopData,
    output logic [BYTE_W-1:0]                o_byte_data,
    output logic                             o_byte_valid,
    input  logic                             i_byte_ready,
    output logic                             o_byte_last,
    output logic                             o_proto_err,
    output logic [15:0]                      o_word_cnt,
    output logic [31:0]                      o_byte_cnt
);

    localparam int WORD_W = BYTE_W * BYTES_PER_WORD;
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam logic [3:0] MAX_AMT = 4'(BYTES_PER_WORD);

    typedef enum logic {ST_EMPTY, ST_SHIFT} state_t;

    state_t            state_q;
    logic [WORD_W-1:0] mem_data [DEPTH];
    logic [3:0]        mem_amt  [DEPTH];
    logic [PTR_W-1:0]  head_q, tail_q, head_next;
    logic [CNT_W-1:0]  count_q, count_next;
    logic [3:0]        idx_q, idx_next;
    logic [3:0]        amt_in, sel_amt;
    logic [WORD_W-1:0] sel_word;
    logic              capture, accept, take, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign amt_in       = (PopAmout > MAX_AMT) ? MAX_AMT : PopAmout;
    assign capture      = PopEnable && PopPermit;
    assign accept       = capture && (amt_in != 4'd0);
    assign take         = o_byte_valid && i_byte_ready;
    assign pop          = take && o_byte_last;
    assign o_byte_valid = (state_q == ST_SHIFT);

    // Next-cycle view of the buffer, so every output can be registered.
    // NOTE: combinational blocks use blocking '=' with a default for every target, so no latch is inferred.
    always_comb begin
        count_next = count_q;
        head_next  = head_q;
        idx_next   = idx_q;
        if (take)
            idx_next = o_byte_last ? 4'd0 : idx_q + 4'd1;
        if (pop)
            head_next = ptr_inc(head_q);
        case ({accept, pop})
            2'b10:   count_next = count_q + 1'b1;
            2'b01:   count_next = count_q - 1'b1;
            default: count_next = count_q;
        endcase
        // The word landing this cycle becomes head when the buffer would otherwise be empty.
        if (accept && (head_next == tail_q)) begin
            sel_word = PopData;
            sel_amt  = amt_in;
        end else begin
            sel_word = mem_data[head_next];
            sel_amt  = mem_amt[head_next];
        end
    end

    // NOTE: the word storage is not reset; count/pointers define validity, so stale contents are never emitted.
    always_ff @(posedge i_core_clk) begin
        if (accept) begin
            mem_data[tail_q] <= PopData;
            mem_amt[tail_q]  <= amt_in;
        end
    end

    // NOTE: sequential state uses non-blocking '<=' so all registers update from the same pre-edge values.
    always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
        if (!i_rx_rstn) begin
            state_q     <= ST_EMPTY;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            idx_q       <= '0;
            PopPermit   <= 1'b0;
            o_byte_data <= '0;
            o_byte_last <= 1'b0;
            o_proto_err <= 1'b0;
        end else begin
            count_q   <= count_next;
            head_q    <= head_next;
            idx_q     <= idx_next;
            PopPermit <= (count_next < CNT_W'(DEPTH));
            if (accept)
                tail_q <= ptr_inc(tail_q);
            if (count_next != '0) begin
                state_q     <= ST_SHIFT;
                o_byte_data <= sel_word[idx_next*BYTE_W +: BYTE_W];
                o_byte_last <= (idx_next == sel_amt - 4'd1);
            end else begin
                state_q     <= ST_EMPTY;
                o_byte_data <= '0;
                o_byte_last <= 1'b0;
            end
            if ((PopEnable && !PopPermit) || (capture && (PopAmout == 4'd0)))
                o_proto_err <= 1'b1;
        end
    end

`ifdef PFIFORM_RD_STATS_EN
    always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
        if (!i_rx_rstn) begin
            o_word_cnt <= '0;
            o_byte_cnt <= '0;
        end else begin
            if (accept)
                o_word_cnt <= o_word_cnt + 16'd1;
            if (take)
                o_byte_cnt <= o_byte_cnt + 32'd1;
        end
    end
`else
    assign o_word_cnt = '0;
    assign o_byte_cnt = '0;
`endif

endmodule
